// File: rtl/jtag_tap_ctrl_if.sv
// jtag_tap_ctrl_if
//
// Pin-level bundle between the TAP controller and the rest of the scan chain.
// TCK and TRST are kept outside the bundle as plain ports.
//
//   TMS, TDI        : TAP mode select and serial data in
//   idr_tdo         : serial output of the downstream ID register
//   TDO, TDO_en     : chip-level serial data out and its valid flag
//   CaptureDR,
//   ShiftDR,
//   UpdateDR,
//   tlr_reset       : data-register strobes decoded from the TAP state
//   idr_select,
//   bypass_select   : register selects decoded from the current instruction
//
// modport slave  : the TAP controller side
// modport master : the side driving the pins (board / testbench / ID register)
`timescale 1ns/1ps

interface jtag_tap_ctrl_if;
    logic TMS;
    logic TDI;
    logic idr_tdo;
    logic TDO;
    logic TDO_en;
    logic CaptureDR;
    logic ShiftDR;
    logic UpdateDR;
    logic tlr_reset;
    logic idr_select;
    logic bypass_select;

    modport slave (
        input  TMS, TDI, idr_tdo,
        output TDO, TDO_en, CaptureDR, ShiftDR, UpdateDR, tlr_reset,
               idr_select, bypass_select
    );

    modport master (
        output TMS, TDI, idr_tdo,
        input  TDO, TDO_en, CaptureDR, ShiftDR, UpdateDR, tlr_reset,
               idr_select, bypass_select
    );
endinterface

// File: rtl/jtag_tap_ctrl.sv
// jtag_tap_ctrl
//
// IEEE 1149.1 TAP controller with a 4-bit instruction register and the 1-bit
// BYPASS register. Tracks the 16-state TAP machine from TMS, decodes the DR
// strobes for the ID register, decodes the instruction into register selects
// and muxes the chip-level TDO.
//
// Ports:
//   TCK   : JTAG clock; state, IR and BYPASS update on posedge, TDO on negedge
//   TRST  : asynchronous active-low TAP reset
//   tap   : jtag_tap_ctrl_if.slave carrying TMS/TDI/idr_tdo in and
//           TDO/TDO_en, the DR strobes and the register selects out
`timescale 1ns/1ps

module jtag_tap_ctrl #(
    parameter int                  IR_WIDTH   = 4,
    parameter logic [IR_WIDTH-1:0] IDCODE_OP  = 4'b0010,
    parameter logic [IR_WIDTH-1:0] BYPASS_OP  = 4'b1111,
    parameter logic [IR_WIDTH-1:0] IR_CAPTURE = 4'b0101
) (
    input  logic           TCK,
    input  logic           TRST,
    jtag_tap_ctrl_if.slave tap
);

    typedef enum logic [3:0] {
        TLR, RTI,
        SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR,
        SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
    } tap_state_t;

    tap_state_t          state;
    logic [IR_WIDTH-1:0] ir_sr;
    logic [IR_WIDTH-1:0] instr;
    logic                bypass_reg;
    logic                tdo_q;
    logic                tdo_en_q;
    logic                idr_sel;
    logic                byp_sel;

    // TAP state machine. The DR and IR columns share the same shape, so only
    // SEL_IR (escape to TLR on TMS=1) differs from its DR counterpart.
    always_ff @(posedge TCK or negedge TRST) begin
        if (!TRST) begin
            state <= TLR;
        end else begin
            case (state)
                TLR:    state <= tap.TMS ? TLR    : RTI;
                RTI:    state <= tap.TMS ? SEL_DR : RTI;
                SEL_DR: state <= tap.TMS ? SEL_IR : CAP_DR;
                CAP_DR: state <= tap.TMS ? EX1_DR : SH_DR;
                SH_DR:  state <= tap.TMS ? EX1_DR : SH_DR;
                EX1_DR: state <= tap.TMS ? UPD_DR : PAU_DR;
                PAU_DR: state <= tap.TMS ? EX2_DR : PAU_DR;
                EX2_DR: state <= tap.TMS ? UPD_DR : SH_DR;
                UPD_DR: state <= tap.TMS ? SEL_DR : RTI;
                SEL_IR: state <= tap.TMS ? TLR    : CAP_IR;
                CAP_IR: state <= tap.TMS ? EX1_IR : SH_IR;
                SH_IR:  state <= tap.TMS ? EX1_IR : SH_IR;
                EX1_IR: state <= tap.TMS ? UPD_IR : PAU_IR;
                PAU_IR: state <= tap.TMS ? EX2_IR : PAU_IR;
                EX2_IR: state <= tap.TMS ? UPD_IR : SH_IR;
                UPD_IR: state <= tap.TMS ? SEL_DR : RTI;
                default: state <= TLR;
            endcase
        end
    end

    // Instruction path: ir_sr captures/shifts on the edge leaving CAP_IR/SH_IR,
    // instr commits on the edge leaving UPD_IR. Every edge spent in TLR forces
    // IDCODE so the part always comes out of reset pointing at the ID register.
    always_ff @(posedge TCK or negedge TRST) begin
        if (!TRST) begin
            ir_sr <= IR_CAPTURE;
            instr <= IDCODE_OP;
        end else begin
            case (state)
                CAP_IR: ir_sr <= IR_CAPTURE;
                SH_IR:  ir_sr <= {tap.TDI, ir_sr[IR_WIDTH-1:1]};
                default: ir_sr <= ir_sr;
            endcase
            if (state == TLR) begin
                instr <= IDCODE_OP;
            end else if (state == UPD_IR) begin
                instr <= ir_sr;
            end
        end
    end

    // BYPASS register: cleared on capture, then a single-stage TDI delay.
    always_ff @(posedge TCK or negedge TRST) begin
        if (!TRST) begin
            bypass_reg <= 1'b0;
        end else if (byp_sel) begin
            if (state == CAP_DR) begin
                bypass_reg <= 1'b0;
            end else if (state == SH_DR) begin
                bypass_reg <= tap.TDI;
            end
        end
    end

    // TDO is launched on the falling edge so it is stable for the next
    // rising edge at the downstream device.
    always_ff @(negedge TCK or negedge TRST) begin
        if (!TRST) begin
            tdo_q    <= 1'b0;
            tdo_en_q <= 1'b0;
        end else begin
            case (state)
                SH_IR: begin
                    tdo_q    <= ir_sr[0];
                    tdo_en_q <= 1'b1;
                end
                SH_DR: begin
                    tdo_q    <= idr_sel ? tap.idr_tdo : bypass_reg;
                    tdo_en_q <= 1'b1;
                end
                default: begin
                    tdo_q    <= 1'b0;
                    tdo_en_q <= 1'b0;
                end
            endcase
        end
    end

    // Only IDCODE selects the ID register; BYPASS and every undefined opcode
    // fall through to BYPASS, keeping the two selects one-hot.
    assign idr_sel = (instr == IDCODE_OP);
    assign byp_sel = (instr == BYPASS_OP) || !idr_sel;

    assign tap.CaptureDR     = (state == CAP_DR);
    assign tap.ShiftDR       = (state == SH_DR);
    assign tap.UpdateDR      = (state == UPD_DR);
    assign tap.tlr_reset     = (state == TLR);
    assign tap.idr_select    = idr_sel;
    assign tap.bypass_select = byp_sel;
    assign tap.TDO           = tdo_q;
    assign tap.TDO_en        = tdo_en_q;

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// tb_jtag_tap_ctrl
//
// Directed bench for jtag_tap_ctrl: reset with TCK stopped, IDCODE DR scan,
// IR scan, BYPASS scan, TLR recovery, undefined opcode and TRST mid-shift.
// Inputs change just after the falling edge; strobes and selects are sampled
// 1 ns after the rising edge, TDO 1 ns after the falling edge.
`timescale 1ns/1ps

module tb_jtag_tap_ctrl;

    logic TCK = 1'b0;
    logic TRST;
    bit   tck_run = 1'b0;

    int n_compared   = 0;
    int n_mismatched = 0;

    logic s_cap, s_shift, s_upd, s_tlr, s_idr, s_byp;
    logic s_tdo, s_tdo_en;

    logic [31:0] id_pattern;
    logic [3:0]  ir_capture_exp;
    logic [3:0]  bypass_tdi;
    logic [3:0]  undef_op;
    int          cap_count;
    int          shift_count;

    jtag_tap_ctrl_if tap ();

    jtag_tap_ctrl dut (
        .TCK  (TCK),
        .TRST (TRST),
        .tap  (tap.slave)
    );

    // Gated clock so reset can be exercised with TCK stopped.
    always begin
        #5;
        if (tck_run) TCK = ~TCK;
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_compared++;
        assert (observed === expected) else begin
            n_mismatched++;
            $error("[TB] FAIL %s: observed %0h required %0h", tag, observed, expected);
        end
    endtask

    // One TCK period: drive inputs, sample strobes after the rising edge,
    // sample TDO after the falling edge.
    task automatic applyStimulus(input logic tms, input logic tdi, input logic idr);
        tap.TMS     = tms;
        tap.TDI     = tdi;
        tap.idr_tdo = idr;
        @(posedge TCK);
        #1;
        s_cap   = tap.CaptureDR;
        s_shift = tap.ShiftDR;
        s_upd   = tap.UpdateDR;
        s_tlr   = tap.tlr_reset;
        s_idr   = tap.idr_select;
        s_byp   = tap.bypass_select;
        @(negedge TCK);
        #1;
        s_tdo    = tap.TDO;
        s_tdo_en = tap.TDO_en;
    endtask

    initial begin
        id_pattern     = 32'hA5C3_1E0F;
        ir_capture_exp = 4'b0101;
        bypass_tdi     = 4'b1101;
        undef_op       = 4'b0110;

        tap.TMS     = 1'b1;
        tap.TDI     = 1'b0;
        tap.idr_tdo = 1'b0;
        TRST        = 1'b1;

        // Reset with the clock stopped
        #2 TRST = 1'b0;
        #2;
        checkOutput("rst_tlr",    tap.tlr_reset,     1'b1);
        checkOutput("rst_idr",    tap.idr_select,    1'b1);
        checkOutput("rst_byp",    tap.bypass_select, 1'b0);
        checkOutput("rst_tdo",    tap.TDO,           1'b0);
        checkOutput("rst_tdo_en", tap.TDO_en,        1'b0);
        checkOutput("rst_cap",    tap.CaptureDR,     1'b0);
        checkOutput("rst_shift",  tap.ShiftDR,       1'b0);
        checkOutput("rst_upd",    tap.UpdateDR,      1'b0);
        #2 TRST = 1'b1;
        #2 tck_run = 1'b1;
        @(negedge TCK);
        #1;

        // TLR holds while TMS=1
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("tlr_hold1", s_tlr, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("tlr_hold2", s_tlr, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("to_rti", s_tlr, 1'b0);

        // IDCODE DR scan: one capture edge, 32 shift edges
        cap_count   = 0;
        shift_count = 0;
        applyStimulus(1'b1, 1'b0, 1'b0);
        cap_count += int'(s_cap);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("capdr_strobe", s_cap,    1'b1);
        checkOutput("capdr_tdo_en", s_tdo_en, 1'b0);
        cap_count   += int'(s_cap);
        shift_count += int'(s_shift);
        for (int k = 0; k < 32; k++) begin
            applyStimulus(1'b0, 1'b0, id_pattern[k]);
            checkOutput($sformatf("idr_tdo%0d", k), s_tdo, id_pattern[k]);
            cap_count   += int'(s_cap);
            shift_count += int'(s_shift);
        end
        applyStimulus(1'b1, 1'b0, 1'b0);
        cap_count   += int'(s_cap);
        shift_count += int'(s_shift);
        checkOutput("idr_exit_tdo_en", s_tdo_en, 1'b0);
        checkOutput("idr_cap_count",   cap_count,   32'd1);
        checkOutput("idr_shift_count", shift_count, 32'd32);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("upddr_strobe", s_upd, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("upddr_clear", s_upd, 1'b0);

        // IR scan: capture value out LSB first, load BYPASS (4'b1111)
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("ir_tdo0",    s_tdo,    ir_capture_exp[0]);
        checkOutput("ir_tdo_en",  s_tdo_en, 1'b1);
        checkOutput("ir_no_shdr", s_shift,  1'b0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(i == 3, 1'b1, 1'b0);
            if (i < 3) begin
                checkOutput($sformatf("ir_tdo%0d", i + 1), s_tdo, ir_capture_exp[i + 1]);
            end else begin
                checkOutput("ir_exit_tdo_en", s_tdo_en, 1'b0);
            end
        end
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("updir_idr_still", s_idr, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("byp_loaded_idr", s_idr, 1'b0);
        checkOutput("byp_loaded_byp", s_byp, 1'b1);

        // BYPASS scan: captured 0, then TDI one cycle late
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("byp_tdo_cap", s_tdo, 1'b0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(i == 3, bypass_tdi[i], 1'b1);
            if (i < 3) begin
                checkOutput($sformatf("byp_tdo%0d", i), s_tdo, bypass_tdi[i]);
            end else begin
                checkOutput("byp_exit_tdo_en", s_tdo_en, 1'b0);
            end
        end

        // Ex1DR -> PauDR -> Ex2DR -> ShDR, then five TMS=1 edges to TLR
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("paudr_shift", s_shift, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("ex2dr_to_shdr", s_shift, 1'b1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
            checkOutput($sformatf("tlr_walk%0d", i), s_tlr, (i == 4));
        end
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("tlr_force_tlr", s_tlr, 1'b1);
        checkOutput("tlr_force_idr", s_idr, 1'b1);
        checkOutput("tlr_force_byp", s_byp, 1'b0);

        // Undefined opcode 4'b0110 selects BYPASS
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(i == 3, undef_op[i], 1'b0);
        end
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("undef_byp", s_byp, 1'b1);
        checkOutput("undef_idr", s_idr, 1'b0);

        // TRST in the middle of an IR shift
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("midshift_tdo_en", s_tdo_en, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        tap.TMS = 1'b1;
        TRST    = 1'b0;
        #1;
        checkOutput("trst_tdo_en", tap.TDO_en,        1'b0);
        checkOutput("trst_tdo",    tap.TDO,           1'b0);
        checkOutput("trst_idr",    tap.idr_select,    1'b1);
        checkOutput("trst_byp",    tap.bypass_select, 1'b0);
        checkOutput("trst_tlr",    tap.tlr_reset,     1'b1);
        #1 TRST = 1'b1;
        @(negedge TCK);
        #1;
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("post_trst_tlr", s_tlr, 1'b1);

        // Fresh IR scan after reset presents the capture LSB again
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("rescan_tdo",    s_tdo,    ir_capture_exp[0]);
        checkOutput("rescan_tdo_en", s_tdo_en, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
